// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and default sizes for the regfile operand-issue stage.
//   DEF_WIDTH / DEF_DEPTH : default data width and architectural register count
//   reg_addr_t, data_t    : register address and data words at default sizes
//   issue_req_t           : decoded source/destination fields of one instruction
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DEPTH = 32;
   localparam int unsigned DEF_AW    = $clog2(DEF_DEPTH);

   typedef logic [DEF_AW-1:0]    reg_addr_t;
   typedef logic [DEF_WIDTH-1:0] data_t;

   typedef struct packed {
      reg_addr_t rs1;
      reg_addr_t rs2;
      reg_addr_t rd;
      logic      rd_wr;
   } issue_req_t;

endpackage

// File: rtl/regfile_issue_if.sv
// -----------------------------------------------------------------------------
// regfile_issue_if
// Bundles the decode, regfile read/write, writeback, flush and execute signals
// of the operand-issue stage. Signal suffixes are relative to the issue stage.
//   slave  : used by the issue stage itself
//   master : used by the surrounding pipeline (or a testbench)
// -----------------------------------------------------------------------------
interface regfile_issue_if
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
);
   localparam int unsigned AW = $clog2(DEPTH);

   // decode side
   logic                     id_valid_i;
   logic                     id_ready_o;
   logic [AW-1:0]            id_rs1_i;
   logic [AW-1:0]            id_rs2_i;
   logic [AW-1:0]            id_rd_i;
   logic                     id_rd_wr_i;
   // regfile read ports (port0 = rs1, port1 = rs2)
   logic [1:0][AW-1:0]       rf_rd_addr_o;
   logic [1:0][WIDTH-1:0]    rf_rd_data_i;
   // writeback and regfile write port
   logic                     wb_valid_i;
   logic [AW-1:0]            wb_addr_i;
   logic [WIDTH-1:0]         wb_data_i;
   logic                     rf_wr_en_o;
   logic [AW-1:0]            rf_wr_addr_o;
   logic [WIDTH-1:0]         rf_wr_data_o;
   // execute side
   logic                     flush_i;
   logic                     ex_valid_o;
   logic                     ex_ready_i;
   logic [WIDTH-1:0]         ex_op_a_o;
   logic [WIDTH-1:0]         ex_op_b_o;
   logic [AW-1:0]            ex_rd_o;
   logic                     ex_rd_wr_o;

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rd_wr_i,
      input  rf_rd_data_i, wb_valid_i, wb_addr_i, wb_data_i,
      input  flush_i, ex_ready_i,
      output id_ready_o, rf_rd_addr_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
      output ex_valid_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_rd_wr_o
   );

   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rd_wr_i,
      output rf_rd_data_i, wb_valid_i, wb_addr_i, wb_data_i,
      output flush_i, ex_ready_i,
      input  id_ready_o, rf_rd_addr_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
      input  ex_valid_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_rd_wr_o
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register, tracking in-flight destinations.
//   clk_i, rst_ni        : clock, async active-low reset (all bits clear)
//   clr_en_i/clr_addr_i  : writeback clear
//   fl_en_i/fl_addr_i    : clear for a flushed destination
//   set_en_i/set_addr_i  : mark a newly issued destination busy (wins over clears)
//   look_addr_i          : three lookup addresses (rs1, rs2, rd)
//   look_busy_o          : combinational busy state of the lookup addresses
// -----------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_en_i,
   input  logic [AW-1:0]      clr_addr_i,
   input  logic               fl_en_i,
   input  logic [AW-1:0]      fl_addr_i,
   input  logic               set_en_i,
   input  logic [AW-1:0]      set_addr_i,
   input  logic [2:0][AW-1:0] look_addr_i,
   output logic [2:0]         look_busy_o
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Clears first, then the set, so a same-cycle set on the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
      if (fl_en_i)  busy_d[fl_addr_i]  = 1'b0;
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   always_comb begin
      look_busy_o = '0;
      for (int i = 0; i < 3; i++) look_busy_o[i] = busy_q[look_addr_i[i]];
   end

endmodule

// File: rtl/regfile_issue.sv
// -----------------------------------------------------------------------------
// regfile_issue
// Operand-issue stage between decode and execute. Reads two sources from the
// regfile, stalls on RAW/WAW hazards against in-flight destinations, routes
// writeback onto the regfile write port and registers operands for execute.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : decode, regfile, writeback, flush and execute signals
// Build option: REGFILE_ISSUE_BYPASS_EN -- a writeback arriving this cycle
// resolves the hazard immediately and its data is forwarded into the operand.
// Without it the instruction waits one more cycle and reads the regfile.
// -----------------------------------------------------------------------------
module regfile_issue
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   regfile_issue_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0]    rs1, rs2, rd;
   logic [2:0]       sb_busy;
   logic             busy_rs1, busy_rs2, busy_rd;
   logic [WIDTH-1:0] op_a, op_b;
   logic             hazard, advance, id_ready, accept;

   logic             ex_valid_q;
   logic [WIDTH-1:0] ex_op_a_q, ex_op_b_q;
   logic [AW-1:0]    ex_rd_q;
   logic             ex_rd_wr_q;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   assign rs1 = bus.id_rs1_i;
   assign rs2 = bus.id_rs2_i;
   assign rd  = bus.id_rd_i;

   assign bus.rf_rd_addr_o[0] = rs1;
   assign bus.rf_rd_addr_o[1] = rs2;

   // Writeback passes straight through to the regfile write port.
   assign bus.rf_wr_en_o   = bus.wb_valid_i && !is_zero(bus.wb_addr_i);
   assign bus.rf_wr_addr_o = bus.wb_addr_i;
   assign bus.rf_wr_data_o = bus.wb_data_i;

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_en_i    (bus.wb_valid_i),
      .clr_addr_i  (bus.wb_addr_i),
      .fl_en_i     (bus.flush_i && ex_valid_q && ex_rd_wr_q),
      .fl_addr_i   (ex_rd_q),
      .set_en_i    (accept && bus.id_rd_wr_i && (rd != '0)),
      .set_addr_i  (rd),
      .look_addr_i ({rd, rs2, rs1}),
      .look_busy_o (sb_busy)
   );

`ifdef REGFILE_ISSUE_BYPASS_EN
   logic hit_rs1, hit_rs2, hit_rd;

   // A writeback to the looked-up register this cycle resolves its hazard.
   assign hit_rs1 = bus.wb_valid_i && (bus.wb_addr_i == rs1) && !is_zero(rs1);
   assign hit_rs2 = bus.wb_valid_i && (bus.wb_addr_i == rs2) && !is_zero(rs2);
   assign hit_rd  = bus.wb_valid_i && (bus.wb_addr_i == rd)  && !is_zero(rd);

   assign busy_rs1 = sb_busy[0] && !hit_rs1 && !is_zero(rs1);
   assign busy_rs2 = sb_busy[1] && !hit_rs2 && !is_zero(rs2);
   assign busy_rd  = sb_busy[2] && !hit_rd  && !is_zero(rd);

   assign op_a = is_zero(rs1) ? '0 : (hit_rs1 ? bus.wb_data_i : bus.rf_rd_data_i[0]);
   assign op_b = is_zero(rs2) ? '0 : (hit_rs2 ? bus.wb_data_i : bus.rf_rd_data_i[1]);
`else
   assign busy_rs1 = sb_busy[0] && !is_zero(rs1);
   assign busy_rs2 = sb_busy[1] && !is_zero(rs2);
   assign busy_rd  = sb_busy[2] && !is_zero(rd);

   assign op_a = is_zero(rs1) ? '0 : bus.rf_rd_data_i[0];
   assign op_b = is_zero(rs2) ? '0 : bus.rf_rd_data_i[1];
`endif

   assign hazard   = busy_rs1 || busy_rs2 || (bus.id_rd_wr_i && busy_rd);
   assign advance  = !ex_valid_q || bus.ex_ready_i;
   assign id_ready = advance && !hazard && !bus.flush_i;
   assign accept   = bus.id_valid_i && id_ready;

   assign bus.id_ready_o = id_ready;

   // Execute-facing register; holds while execute back-pressures.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_valid_q <= 1'b0;
         ex_op_a_q  <= '0;
         ex_op_b_q  <= '0;
         ex_rd_q    <= '0;
         ex_rd_wr_q <= 1'b0;
      end else if (bus.flush_i) begin
         ex_valid_q <= 1'b0;
      end else if (advance) begin
         ex_valid_q <= accept;
         if (accept) begin
            ex_op_a_q  <= op_a;
            ex_op_b_q  <= op_b;
            ex_rd_q    <= rd;
            ex_rd_wr_q <= bus.id_rd_wr_i;
         end
      end
   end

   assign bus.ex_valid_o = ex_valid_q;
   assign bus.ex_op_a_o  = ex_op_a_q;
   assign bus.ex_op_b_o  = ex_op_b_q;
   assign bus.ex_rd_o    = ex_rd_q;
   assign bus.ex_rd_wr_o = ex_rd_wr_q;

endmodule

// File: tb/tb_regfile_issue.sv
// -----------------------------------------------------------------------------
// tb_regfile_issue
// Directed scenarios plus randomized traffic for regfile_issue, checked against
// a cycle-level reference model (busy array, architectural register values,
// execute-stage slot). The regfile itself is modelled as an array written
// through the DUT's write port.
// -----------------------------------------------------------------------------
module tb_regfile_issue;
   import regfile_pkg::*;

   localparam int unsigned W = DEF_WIDTH;
   localparam int unsigned D = DEF_DEPTH;
`ifdef REGFILE_ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   regfile_issue_if #(.WIDTH(W), .DEPTH(D)) bus ();

   regfile_issue #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   // Environment regfile, written through the DUT's write port.
   data_t rf_mem [D];
   assign bus.rf_rd_data_i = {rf_mem[bus.rf_rd_addr_o[1]], rf_mem[bus.rf_rd_addr_o[0]]};
   always @(posedge clk) if (bus.rf_wr_en_o) rf_mem[bus.rf_wr_addr_o] <= bus.rf_wr_data_o;

   // Reference model state
   bit        busy_m [D];
   data_t     arch   [D];
   bit        exv_m;
   data_t     exa_m, exb_m;
   reg_addr_t exrd_m;
   bit        exwr_m;

   int n_chk = 0;
   int n_fail = 0;

   function automatic bit m_hit(input reg_addr_t r);
      return bus.wb_valid_i && (bus.wb_addr_i == r) && (r != 0);
   endfunction

   function automatic bit m_busy(input reg_addr_t r);
      return (r != 0) && busy_m[r] && !(BYP && m_hit(r));
   endfunction

   function automatic data_t m_op(input reg_addr_t r);
      if (r == 0) return '0;
      if (BYP && m_hit(r)) return bus.wb_data_i;
      return arch[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) busy_m[i] = 1'b0;
      exv_m = 1'b0; exa_m = '0; exb_m = '0; exrd_m = '0; exwr_m = 1'b0;
   endtask

   task automatic set_id(input bit v, input reg_addr_t r1, input reg_addr_t r2,
                         input reg_addr_t rdd, input bit wr);
      bus.id_valid_i = v; bus.id_rs1_i = r1; bus.id_rs2_i = r2;
      bus.id_rd_i = rdd; bus.id_rd_wr_i = wr;
   endtask

   task automatic set_wb(input bit v, input reg_addr_t a, input data_t d);
      bus.wb_valid_i = v; bus.wb_addr_i = a; bus.wb_data_i = d;
   endtask

   // One clock: check combinational outputs, take the edge, check the
   // registered outputs and busy vector against the model.
   task automatic step(input string tag, output bit rdy_dut);
      bit hz, adv, rdy, acc, exp_en, idv, rdwr, wbv, fl, exr;
      reg_addr_t r1, r2, rdd, wa;
      data_t oa, ob, wd;
      logic [D-1:0] bm;
      #1;
      idv = bus.id_valid_i; r1 = bus.id_rs1_i; r2 = bus.id_rs2_i;
      rdd = bus.id_rd_i; rdwr = bus.id_rd_wr_i;
      wbv = bus.wb_valid_i; wa = bus.wb_addr_i; wd = bus.wb_data_i;
      fl = bus.flush_i; exr = bus.ex_ready_i;
      hz  = m_busy(r1) || m_busy(r2) || (rdwr && m_busy(rdd));
      adv = !exv_m || exr;
      rdy = adv && !hz && !fl;
      acc = idv && rdy;
      oa = m_op(r1); ob = m_op(r2);
      exp_en = wbv && (wa != 0);
      rdy_dut = bus.id_ready_o;
      n_chk++;
      if (bus.id_ready_o !== rdy) begin
         n_fail++; $display("FAIL %s id_ready: got %b exp %b", tag, bus.id_ready_o, rdy);
      end
      n_chk++;
      if (bus.rf_rd_addr_o[0] !== r1 || bus.rf_rd_addr_o[1] !== r2) begin
         n_fail++; $display("FAIL %s rf_rd_addr: got %h/%h exp %h/%h", tag,
                            bus.rf_rd_addr_o[0], bus.rf_rd_addr_o[1], r1, r2);
      end
      n_chk++;
      if (bus.rf_wr_en_o !== exp_en) begin
         n_fail++; $display("FAIL %s rf_wr_en: got %b exp %b", tag, bus.rf_wr_en_o, exp_en);
      end
      if (exp_en) begin
         n_chk++;
         if (bus.rf_wr_addr_o !== wa || bus.rf_wr_data_o !== wd) begin
            n_fail++; $display("FAIL %s rf_wr: got %h:%h exp %h:%h", tag,
                               bus.rf_wr_addr_o, bus.rf_wr_data_o, wa, wd);
         end
      end
      @(posedge clk);
      #1;
      if (wbv && wa != 0) arch[wa] = wd;
      if (wbv) busy_m[wa] = 1'b0;
      if (fl && exv_m && exwr_m) busy_m[exrd_m] = 1'b0;
      if (acc && rdwr && rdd != 0) busy_m[rdd] = 1'b1;
      if (fl) exv_m = 1'b0;
      else if (adv) begin
         exv_m = acc;
         if (acc) begin exa_m = oa; exb_m = ob; exrd_m = rdd; exwr_m = rdwr; end
      end
      n_chk++;
      if (bus.ex_valid_o !== exv_m) begin
         n_fail++; $display("FAIL %s ex_valid: got %b exp %b", tag, bus.ex_valid_o, exv_m);
      end
      if (exv_m) begin
         n_chk++;
         if (bus.ex_op_a_o !== exa_m || bus.ex_op_b_o !== exb_m ||
             bus.ex_rd_o !== exrd_m || bus.ex_rd_wr_o !== exwr_m) begin
            n_fail++; $display("FAIL %s ex_payload: got %h %h %h %b exp %h %h %h %b", tag,
                               bus.ex_op_a_o, bus.ex_op_b_o, bus.ex_rd_o, bus.ex_rd_wr_o,
                               exa_m, exb_m, exrd_m, exwr_m);
         end
      end
      for (int i = 0; i < D; i++) bm[i] = busy_m[i];
      n_chk++;
      if (dut.u_sb.busy_q !== bm) begin
         n_fail++; $display("FAIL %s busy: got %h exp %h", tag, dut.u_sb.busy_q, bm);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      set_id(1'b0, '0, '0, '0, 1'b0);
      set_wb(1'b0, '0, '0);
      bus.flush_i = 1'b0; bus.ex_ready_i = 1'b1;
      model_reset();
      #3;
      n_chk++;
      if (bus.ex_valid_o !== 1'b0 || bus.ex_op_a_o !== '0 || bus.ex_op_b_o !== '0 ||
          bus.ex_rd_o !== '0 || bus.ex_rd_wr_o !== 1'b0) begin
         n_fail++; $display("FAIL reset ex_*: got %b %h %h %h %b", bus.ex_valid_o,
                            bus.ex_op_a_o, bus.ex_op_b_o, bus.ex_rd_o, bus.ex_rd_wr_o);
      end
      n_chk++;
      if (dut.u_sb.busy_q !== '0) begin
         n_fail++; $display("FAIL reset busy: got %h exp 0", dut.u_sb.busy_q);
      end
      @(negedge clk); rst_ni = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_preload();
      bit r;
      set_id(1'b0, '0, '0, '0, 1'b0);
      for (int i = 1; i < D; i++) begin
         set_wb(1'b1, reg_addr_t'(i), data_t'(i * 100));
         step("preload", r);
      end
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_basic();
      bit r;
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
      step("basic", r);
      n_chk++;
      if (r !== 1'b1 || bus.ex_op_a_o !== 32'd100 || bus.ex_op_b_o !== 32'd200 ||
          bus.ex_rd_o !== 5'd5 || dut.u_sb.busy_q[5] !== 1'b1) begin
         n_fail++; $display("FAIL basic_issue: got rdy=%b a=%0d b=%0d rd=%0d busy5=%b exp 1 100 200 5 1",
                            r, bus.ex_op_a_o, bus.ex_op_b_o, bus.ex_rd_o, dut.u_sb.busy_q[5]);
      end
      set_id(1'b0, '0, '0, '0, 1'b0);
      set_wb(1'b1, 5'd5, 32'h555);
      step("basic_wb", r);
      n_chk++;
      if (bus.ex_valid_o !== 1'b0 || dut.u_sb.busy_q[5] !== 1'b0) begin
         n_fail++; $display("FAIL basic_retire: got valid=%b busy5=%b exp 0 0",
                            bus.ex_valid_o, dut.u_sb.busy_q[5]);
      end
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_raw();
      bit r;
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
      step("raw_prod", r);
      set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step("raw_stall", r);
         n_chk++;
         if (r !== 1'b0) begin
            n_fail++; $display("FAIL raw_stall: got id_ready %b exp 0", r);
         end
      end
      set_wb(1'b1, 5'd5, 32'hDEADBEEF);
      step("raw_wb", r);
`ifdef REGFILE_ISSUE_BYPASS_EN
      n_chk++;
      if (r !== 1'b1 || bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL raw_bypass: got rdy=%b valid=%b a=%h exp 1 1 deadbeef",
                            r, bus.ex_valid_o, bus.ex_op_a_o);
      end
`else
      n_chk++;
      if (r !== 1'b0) begin
         n_fail++; $display("FAIL raw_wb_cycle: got id_ready %b exp 0", r);
      end
      set_wb(1'b0, '0, '0);
      step("raw_after", r);
      n_chk++;
      if (r !== 1'b1 || bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL raw_nobypass: got rdy=%b valid=%b a=%h exp 1 1 deadbeef",
                            r, bus.ex_valid_o, bus.ex_op_a_o);
      end
`endif
      set_id(1'b0, '0, '0, '0, 1'b0);
      set_wb(1'b1, 5'd6, 32'h666);
      step("raw_clean", r);
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_backpressure();
      bit r;
      bus.ex_ready_i = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
      step("bp_issue", r);
      set_id(1'b1, 5'd3, 5'd4, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step("bp_hold", r);
         n_chk++;
         if (r !== 1'b0 || bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'd100 ||
             bus.ex_op_b_o !== 32'd200 || bus.ex_rd_o !== 5'd8) begin
            n_fail++; $display("FAIL bp_hold: got rdy=%b v=%b a=%0d b=%0d rd=%0d exp 0 1 100 200 8",
                               r, bus.ex_valid_o, bus.ex_op_a_o, bus.ex_op_b_o, bus.ex_rd_o);
         end
      end
      bus.ex_ready_i = 1'b1;
      step("bp_release", r);
      n_chk++;
      if (r !== 1'b1 || bus.ex_op_a_o !== 32'd300 || bus.ex_op_b_o !== 32'd400) begin
         n_fail++; $display("FAIL bp_release: got rdy=%b a=%0d b=%0d exp 1 300 400",
                            r, bus.ex_op_a_o, bus.ex_op_b_o);
      end
      set_id(1'b0, '0, '0, '0, 1'b0);
      set_wb(1'b1, 5'd8, 32'h888);
      step("bp_clean", r);
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_zero_reg();
      bit r;
      set_id(1'b1, 5'd0, 5'd2, 5'd0, 1'b1);
      set_wb(1'b1, 5'd0, 32'h12345678);
      #1;
      n_chk++;
      if (bus.rf_wr_en_o !== 1'b0) begin
         n_fail++; $display("FAIL zero_wr_en: got %b exp 0", bus.rf_wr_en_o);
      end
      step("zero_issue", r);
      n_chk++;
      if (r !== 1'b1 || bus.ex_op_a_o !== 32'd0 || bus.ex_op_b_o !== 32'd200 ||
          dut.u_sb.busy_q[0] !== 1'b0) begin
         n_fail++; $display("FAIL zero_issue: got rdy=%b a=%h b=%0d busy0=%b exp 1 0 200 0",
                            r, bus.ex_op_a_o, bus.ex_op_b_o, dut.u_sb.busy_q[0]);
      end
      set_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b0);
      set_wb(1'b0, '0, '0);
      step("zero_again", r);
      n_chk++;
      if (r !== 1'b1 || bus.ex_op_a_o !== 32'd0) begin
         n_fail++; $display("FAIL zero_again: got rdy=%b a=%h exp 1 0", r, bus.ex_op_a_o);
      end
      set_id(1'b0, '0, '0, '0, 1'b0);
      step("zero_idle", r);
   endtask

   task automatic test_flush();
      bit r;
      bus.ex_ready_i = 1'b0;
      set_id(1'b1, 5'd1, 5'd1, 5'd7, 1'b1);
      step("fl_issue", r);
      n_chk++;
      if (dut.u_sb.busy_q[7] !== 1'b1 || bus.ex_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL fl_held: got busy7=%b valid=%b exp 1 1",
                            dut.u_sb.busy_q[7], bus.ex_valid_o);
      end
      set_id(1'b0, '0, '0, '0, 1'b0);
      bus.flush_i = 1'b1;
      step("fl_flush", r);
      n_chk++;
      if (r !== 1'b0 || bus.ex_valid_o !== 1'b0 || dut.u_sb.busy_q[7] !== 1'b0) begin
         n_fail++; $display("FAIL fl_flush: got rdy=%b valid=%b busy7=%b exp 0 0 0",
                            r, bus.ex_valid_o, dut.u_sb.busy_q[7]);
      end
      bus.flush_i = 1'b0;
      bus.ex_ready_i = 1'b1;
      set_id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
      step("fl_reuse", r);
      n_chk++;
      if (r !== 1'b1 || bus.ex_op_a_o !== 32'd700) begin
         n_fail++; $display("FAIL fl_reuse: got rdy=%b a=%0d exp 1 700", r, bus.ex_op_a_o);
      end
      set_id(1'b0, '0, '0, '0, 1'b0);
      step("fl_idle", r);
   endtask

   task automatic test_reset_mid();
      bit r;
      bus.ex_ready_i = 1'b1;
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
      step("rm_prod", r);
      bus.ex_ready_i = 1'b0;
      set_id(1'b1, 5'd3, 5'd0, 5'd9, 1'b1);
      step("rm_stall", r);
      n_chk++;
      if (r !== 1'b0 || bus.ex_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL rm_stall: got rdy=%b valid=%b exp 0 1", r, bus.ex_valid_o);
      end
      #3;
      rst_ni = 1'b0;
      #1;
      n_chk++;
      if (bus.ex_valid_o !== 1'b0 || dut.u_sb.busy_q !== '0) begin
         n_fail++; $display("FAIL rm_async: got valid=%b busy=%h exp 0 0",
                            bus.ex_valid_o, dut.u_sb.busy_q);
      end
      model_reset();
      #2;
      rst_ni = 1'b1;
      step("rm_after", r);
      n_chk++;
      if (r !== 1'b1 || bus.ex_op_a_o !== 32'd300) begin
         n_fail++; $display("FAIL rm_after: got rdy=%b a=%0d exp 1 300", r, bus.ex_op_a_o);
      end
      bus.ex_ready_i = 1'b1;
      set_id(1'b0, '0, '0, '0, 1'b0);
      set_wb(1'b1, 5'd9, 32'h999);
      step("rm_clean", r);
      set_wb(1'b0, '0, '0);
   endtask

   task automatic test_random();
      bit r;
      issue_req_t q;
      reg_addr_t pend [$];
      reg_addr_t wa;
      for (int c = 0; c < 1500; c++) begin
         q = issue_req_t'(16'($urandom));
         q.rs1 = q.rs1 & 5'd7;
         q.rs2 = q.rs2 & 5'd7;
         q.rd  = q.rd  & 5'd7;
         set_id($urandom_range(0, 3) != 0, q.rs1, q.rs2, q.rd, q.rd_wr);
         pend.delete();
         for (int i = 0; i < D; i++) if (busy_m[i]) pend.push_back(reg_addr_t'(i));
         if (pend.size() != 0 && $urandom_range(0, 1) == 1)
            wa = pend[$urandom_range(0, pend.size() - 1)];
         else
            wa = reg_addr_t'($urandom_range(0, 7));
         set_wb($urandom_range(0, 9) < 4, wa, data_t'($urandom));
         bus.flush_i    = ($urandom_range(0, 19) == 0);
         bus.ex_ready_i = ($urandom_range(0, 3) != 0);
         step("rand", r);
      end
      set_id(1'b0, '0, '0, '0, 1'b0);
      set_wb(1'b0, '0, '0);
      bus.flush_i = 1'b0;
      bus.ex_ready_i = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < D; i++) arch[i] = '0;
      test_reset();
      test_preload();
      test_basic();
      test_raw();
      test_backpressure();
      test_zero_reg();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_issue.md
Name: regfile_issue

Overview:
- Operand-issue stage directly upstream of the register file's read ports and downstream of decode.
- Accepts one decoded instruction per cycle and reads its two source operands from the regfile.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards.
- Forwards same-cycle writeback data and registers operands into a valid/ready stage for execute. It also routes writeback onto the regfile write port.

Parameters:
- WIDTH, 32, operand/data width in bits.
- DEPTH, 32, number of architectural registers; AW = $clog2(DEPTH).
- ZERO_REG, 1, when 1, register 0 is never marked busy and always reads as 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode has an instruction
- id_ready_o  out  1  stage accepts the instruction this cycle
- id_rs1_i, id_rs2_i  in  AW each  source register addresses
- id_rd_i  in  AW  destination register address
- id_rd_wr_i  in  1  instruction writes rd
- rf_rd_addr_o  out  2xAW  regfile read addresses; port0=rs1, port1=rs2; combinational from id_rs*
- rf_rd_data_i  in  2xWIDTH  regfile read data; combinational return
- wb_valid_i  in  1  writeback this cycle
- wb_addr_i  in  AW  writeback register
- wb_data_i  in  WIDTH  writeback data
- rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o  out  1/AW/WIDTH  combinational copy of wb_*; en is forced 0 for addr 0 when ZERO_REG=1
- flush_i  in  1  discard the instruction held in the output register
- ex_valid_o  out  1  operands valid for execute
- ex_ready_i  in  1  execute accepts
- ex_op_a_o, ex_op_b_o  out  WIDTH each  registered operands
- ex_rd_o  out  AW  registered rd
- ex_rd_wr_o  out  1  registered rd write enable

Behaviour:
- Reset: busy[] all 0; ex_valid_o=0; ex_op_a_o, ex_op_b_o, ex_rd_o and ex_rd_wr_o all 0. rf_* and id_ready_o are combinational.
- advance = !ex_valid_o || ex_ready_i.
- src_busy(r) = busy[r] && !(wb_valid_i && wb_addr_i==r). Bypass is per the optional feature; r=0 is never busy when ZERO_REG=1.
- hazard = src_busy(rs1) || src_busy(rs2) || (id_rd_wr_i && busy[rd] && !(wb hit on rd)).
- id_ready_o = advance && !hazard && !flush_i.
- accept = id_valid_i && id_ready_o.
- Operand select per source: if wb_valid_i hits the address (and it is not reg 0), use wb_data_i; else use rf_rd_data_i. Reg 0 yields 0.
- Latency: accept at edge N gives ex_valid_o=1 after edge N, with operands captured at N.
- Output register updates only when advance. On advance without accept, ex_valid_o <= 0.
- Output holds stable while ex_valid_o && !ex_ready_i.
- Scoreboard, per cycle:
  - Clear busy[wb_addr_i] on wb_valid_i.
  - Set busy[id_rd_i] on accept && id_rd_wr_i && rd!=0.
  - Same register set and cleared in one cycle: set wins.
- flush_i:
  - Clears ex_valid_o at the edge.
  - If ex_valid_o && ex_rd_wr_o, also clears busy[ex_rd_o]. Set wins if the same register is concurrently accepted.
  - id_ready_o is 0 during flush.
- Writebacks for registers not marked busy are legal; busy stays 0.
- Reset asserted mid-operation: all state returns to reset values immediately; no pending writebacks are retained.

Optional Feature:
- Macro REGFILE_ISSUE_BYPASS_EN.
- Defined: a source or rd whose writeback arrives this cycle is not a hazard, and wb_data_i is forwarded into the captured operand.
- Undefined: src_busy(r)=busy[r] with no wb exemption. The instruction stalls through the writeback cycle and issues the next cycle, reading the regfile's committed value. No wb_data_i muxing is instantiated.

Decomposition:
- Package regfile_pkg: reg_addr_t (logic [AW-1:0]), data_t, and a struct issue_req_t {rs1, rs2, rd, rd_wr}. DEPTH and WIDTH defaults are package localparams.
- Sub-module regfile_scoreboard: busy vector, set/clear/flush-clear ports, and combinational busy lookup for three addresses.

Test Plan:
- Basic issue: regs 1=100, 2=200; issue rs1=1, rs2=2, rd=5, ex_ready_i=1. Expect ex_op_a_o=100 and ex_op_b_o=200 one cycle later, with busy[5]=1.
- RAW stall: issue rd=5, then rs1=5. Expect id_ready_o=0 until wb_valid_i with addr 5, data 32'hDEADBEEF.
  - With bypass: issues in the wb cycle and ex_op_a_o=DEADBEEF.
  - Without bypass: issues one cycle later, also with DEADBEEF.
- Backpressure: hold ex_ready_i=0 for 3 cycles with valid output. Expect ex_* stable and id_ready_o=0; the next instruction issues on the cycle ex_ready_i=1.
- Zero register: issue rd=0 and rs1=0; wb to addr 0 with 32'h12345678. Expect no stall, ex_op_a_o=0, rf_wr_en_o=0.
- Flush: the held instruction has rd=7 with busy[7]=1; assert flush_i. Expect ex_valid_o=0 and busy[7]=0 next cycle; a later rs1=7 issues without stall.
- Reset mid-stall: busy[3]=1 with an instruction stalled; pulse rst_ni low asynchronously. Expect ex_valid_o=0 immediately and busy cleared; after release, rs1=3 issues with no stall.
